// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
//   Shared definitions for the HI/LO multiply/divide resource:
//   - mul_ctrl_e    : E-stage operation codes carried on mulCtrl
//   - state_e       : sequencer FSM states
//   - *_DEFAULT     : default busy latencies for the two op classes
//   - helper functions that classify an operation code
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

  typedef enum logic [3:0] {
    MT_DISABLED = 4'd0,
    MT_SET_HI   = 4'd1,
    MT_SET_LO   = 4'd2,
    MT_MULT     = 4'd3,
    MT_MULTU    = 4'd4,
    MT_MADD     = 4'd5,
    MT_MADDU    = 4'd6,
    MT_MSUB     = 4'd7,
    MT_DIV      = 4'd8,
    MT_DIVU     = 4'd9
  } mul_ctrl_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int unsigned MUL_CYCLES_DEFAULT = 5;
  localparam int unsigned DIV_CYCLES_DEFAULT = 10;

  // Operations that go through the multi-cycle path.
  function automatic logic is_arith(input logic [3:0] op);
    return (op >= MT_MULT) && (op <= MT_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MT_DIV) || (op == MT_DIVU);
  endfunction

  // Any recognised operation; unknown codes behave like MT_DISABLED.
  function automatic logic is_valid_op(input logic [3:0] op);
    return (op >= MT_SET_HI) && (op <= MT_DIVU);
  endfunction

endpackage : muldiv_sequencer_pkg

// File: rtl/muldiv_sequencer_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
//   Purely combinational HI/LO arithmetic. Given an operation, two operands and
//   the current {HI,LO}, produces the {HI,LO} value the operation would leave.
//   Ports:
//     op         in  4   operation code (mul_ctrl_e encodings)
//     operand_a  in  32  rs value (multiplicand / dividend)
//     operand_b  in  32  rt value (multiplier / divisor)
//     hilo_cur   in  64  current {HI,LO}, accumulate base for madd/maddu/msub
//     hilo_next  out 64  resulting {HI,LO}; equals hilo_cur for non-arith ops
// -----------------------------------------------------------------------------
module muldiv_core
  import muldiv_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [63:0] hilo_cur,
  output logic [63:0] hilo_next
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quot;
  logic [31:0] rem;

  // Sign/zero extend to 64 bits so the low 64 bits of the product are exact.
  assign prod_s = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};
  assign prod_u = {32'd0, operand_a} * {32'd0, operand_b};

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    hilo_next = hilo_cur;
    quot      = '0;
    rem       = '0;
    case (op)
      MT_MULT:  hilo_next = prod_s;
      MT_MULTU: hilo_next = prod_u;
      MT_MADD:  hilo_next = hilo_cur + prod_s;
      MT_MADDU: hilo_next = hilo_cur + prod_u;
      MT_MSUB:  hilo_next = hilo_cur - prod_s;
      MT_DIV: begin
        if (operand_b == 32'd0) begin
          quot = 32'hFFFF_FFFF;
          rem  = operand_a;
        end else if (operand_a == 32'h8000_0000 && operand_b == 32'hFFFF_FFFF) begin
          // Quotient +2^31 is not representable; wrap like two's complement.
          quot = 32'h8000_0000;
          rem  = 32'd0;
        end else begin
          // Signed / and % truncate toward zero; remainder follows dividend.
          quot = $signed(operand_a) / $signed(operand_b);
          rem  = $signed(operand_a) % $signed(operand_b);
        end
        hilo_next = {rem, quot};
      end
      MT_DIVU: begin
        if (operand_b == 32'd0) begin
          quot = 32'hFFFF_FFFF;
          rem  = operand_a;
        end else begin
          quot = operand_a / operand_b;
          rem  = operand_a % operand_b;
        end
        hilo_next = {rem, quot};
      end
      default: hilo_next = hilo_cur;
    endcase
  end

endmodule : muldiv_core

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   E-stage sequencer for the HI/LO multiply/divide resource. Holds HI/LO,
//   models the arithmetic latency with a down-counter, stalls later HI/LO
//   instructions while an operation is in flight, and drops flushed work.
//   Parameters:
//     MUL_CYCLES  busy cycles for mult/multu/madd/maddu/msub (1..15)
//     DIV_CYCLES  busy cycles for div/divu (1..15)
//   Ports:
//     clk           in  1   clock, rising edge
//     reset_n       in  1   asynchronous active-low reset
//     mulCtrl       in  4   E-stage operation code
//     operandA      in  32  forwarded rs
//     operandB      in  32  forwarded rt
//     readRequest   in  1   E-stage instruction is mfhi/mflo
//     mulOutputSel  in  1   read select: 1 = HI, 0 = LO
//     flush         in  1   kill E-stage instruction / abort in-flight op
//     result        out 32  selected HI or LO (combinational)
//     busy          out 1   operation in flight
//     stall         out 1   freeze F/D/E this cycle
//     hi, lo        out 32  architectural HI/LO
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  mulCtrl,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        readRequest,
  input  logic        mulOutputSel,
  input  logic        flush,
  output logic [31:0] result,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter is loaded with LAT-1 so busy lasts exactly LAT cycles.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_e      state, state_next;
  logic [3:0]  count, count_next;
  logic [63:0] pend, pend_next;
  logic [31:0] hi_next, lo_next;
  logic [63:0] core_hilo;

  muldiv_core u_core (
    .op        (mulCtrl),
    .operand_a (operandA),
    .operand_b (operandB),
    .hilo_cur  ({hi, lo}),
    .hilo_next (core_hilo)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      count <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      pend  <= pend_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    pend_next  = pend;
    hi_next    = hi;
    lo_next    = lo;
    case (state)
      ST_IDLE: begin
        if (!flush) begin
          if (mulCtrl == MT_SET_HI) begin
            hi_next = operandA;
          end else if (mulCtrl == MT_SET_LO) begin
            lo_next = operandA;
          end else if (is_arith(mulCtrl)) begin
            pend_next  = core_hilo;
            count_next = is_div(mulCtrl) ? DIV_LOAD : MUL_LOAD;
            state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          // Abort wins over a same-cycle commit; HI/LO stay untouched.
          state_next = ST_IDLE;
          count_next = '0;
        end else if (count == 4'd0) begin
          hi_next    = pend[63:32];
          lo_next    = pend[31:0];
          state_next = ST_IDLE;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy   = (state == ST_BUSY);
  assign stall  = busy && (is_valid_op(mulCtrl) || readRequest);
  assign result = mulOutputSel ? hi : lo;

endmodule : muldiv_sequencer

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the HI/LO multiply/divide resource. It sits in the E stage beside the ALU and consumes the decoder's `mulCtrl`/`mulOutputSel` fields. It holds the HI/LO architectural registers, models the multiplier/divider latency with a down-counter, and raises a pipeline stall while a later HI/LO instruction must wait. It also discards an operation that is flushed by an exception.

## Interface
Parameters:
- `MUL_CYCLES`, 5: busy cycles for mult/multu/madd/maddu/msub; legal range 1..15.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mulCtrl`  in  4  E-stage operation code (`mt*` encodings); `mtDisabled` means no operation.
- `operandA`  in  32  forwarded rs value.
- `operandB`  in  32  forwarded rt value.
- `readRequest`  in  1  E-stage instruction is mfhi/mflo.
- `mulOutputSel`  in  1  1 = HI, 0 = LO.
- `flush`  in  1  kill the E-stage instruction and abort any in-flight operation.
- `result`  out  32  selected HI or LO, combinational.
- `busy`  out  1  operation in flight.
- `stall`  out  1  freeze the F/D/E stages this cycle.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- State machine:
  - States are IDLE and BUSY.
  - There is a 4-bit `count` register and 64-bit `pendHi`/`pendLo` pending registers.
- Issue happens in IDLE when `mulCtrl` is not `mtDisabled` and `flush` = 0:
  - **mtSetHI / mtSetLO:** write `operandA` into HI or LO at the edge. No BUSY, no stall.
  - **Arithmetic ops:** the sub-module result is latched into the pending registers, `count` is loaded with LAT-1, and the state moves to BUSY. LAT is `MUL_CYCLES` or `DIV_CYCLES` for the op class.
- In BUSY, `count` decrements each cycle. In the cycle with `count` = 0, the pending value commits to HI/LO at the edge and the state returns to IDLE.
- Arithmetic rules:
  - **mult:** signed 32x32→64. **multu:** unsigned 32x32→64. HI = result[63:32], LO = result[31:0].
  - **madd / maddu:** {HI,LO} += product, signed or unsigned respectively. **msub:** {HI,LO} -= signed product.
  - **Accumulate base:** madd/maddu/msub accumulate on the {HI,LO} value at issue. HI/LO cannot change during BUSY, so this value is always current.
  - **div / divu:** LO = quotient, HI = remainder, truncating toward zero; the remainder takes the sign of the dividend.
  - **Divide by zero:** LO = 0xFFFFFFFF, HI = operandA.
  - **Signed overflow:** 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- `stall` = `busy` && (`mulCtrl` != `mtDisabled` || `readRequest`). Stalled E-stage inputs are held steady by the pipeline.
- Read path:
  - `result` = `mulOutputSel` ? HI : LO.
  - `result` is valid whenever `stall` = 0.
- Flush behaviour:
  - `flush` in IDLE suppresses any issue, including mtSetHI/mtSetLO.
  - `flush` in BUSY returns to IDLE next edge without committing; HI/LO are unchanged.
  - `flush` takes priority over a commit in the same cycle.
- Any unrecognised `mulCtrl` code is treated as `mtDisabled`.

## Timing
- Reset (asynchronous, while `reset_n` = 0):
  - State is IDLE; `count` = 0; HI = LO = 0; pending registers = 0.
  - Outputs: `busy` = 0, `stall` = 0, `result` = 0.
- Latency: for an op issued at edge t:
  - `busy` is 1 for exactly LAT cycles following t.
  - New HI/LO are visible in the first cycle after `busy` falls.
- A dependent mfhi that arrives during BUSY stalls until `busy` = 0, then reads the committed value in that same cycle.
- Back-to-back ops: a second arithmetic op presented during BUSY stalls. It issues in the first IDLE cycle, with no dead cycle between them.
- `reset_n` asserted mid-operation aborts immediately; no commit occurs.

## Structure
- Shared package/header holds the `mt*` operation encodings and the LAT defaults. This block defines no new global encodings.
- Sub-module `muldiv_core`: combinational; takes op, operands and the current {HI,LO}, and produces the 64-bit next {HI,LO}. It contains all arithmetic, including the divide-by-zero and overflow special cases.
- `muldiv_sequencer` itself contains only the FSM, counter, pending registers, stall and read muxing.

## Test plan
- **Reset mid-op:** mult 3×4, assert `reset_n` = 0 at busy cycle 2 → `busy` = 0 immediately; after release HI = LO = 0.
- **Signed multiply latency:** mult 0xFFFFFFFE × 3, then mflo the next cycle → `stall` high for 5 cycles; `result` = 0xFFFFFFFA; HI = 0xFFFFFFFF.
- **Division cases:**
  - div 7 / -2 → LO = 0xFFFFFFFD, HI = 1; `busy` high exactly 10 cycles.
  - divu 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- **madd accumulate:** mthi 0, mtlo 0xFFFFFFFF, then madd 1×1 → HI = 1, LO = 0.
- **Flush:**
  - mult issued, then `flush` pulsed at busy cycle 3 → `busy` drops next edge; HI/LO keep their prior values.
  - mtlo with `flush` = 1 → LO is unchanged.
- **Back-to-back:** multu 0xFFFFFFFF × 2 followed immediately by divu 9 / 4 → the divu stalls 5 cycles and then issues with no gap. Final LO = 2, HI = 1.
